fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage for the LEGv8 datapath. Holds the PC and issues
//   word fetches to instruction memory over a req/ack handshake. Buffers the
//   returned instruction words, each with its PC, in a small FIFO. Presents the
//   head entry to decode (opcode decode, signext, regfile) via valid/ready.
//   Executes/memory stage redirects (CBZ taken, etc.) flush the stage.
// PARAMETERS
//   N         64   PC/address width in bits
//   RESET_PC  0    PC loaded on reset (N bits, low 2 bits must be 00)
//   DEPTH     2    instruction FIFO entries, >=1
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   reset        in   1   synchronous, active-high reset
//   imem_req     out  1   fetch request; held high until imem_ack
//   imem_addr    out  N   fetch byte address; stable while imem_req high
//   imem_ack     in   1   rdata valid this cycle; completes current request
//   imem_rdata   in   32  instruction word; sampled only when imem_ack=1
//   redirect     in   1   control-flow change; flushes the stage
//   redirect_pc  in   N   new PC; bits [1:0] ignored and forced to 00
//   dec_valid    out  1   dec_instr/dec_pc hold a valid entry
//   dec_ready    in   1   decode accepts the entry this cycle
//   dec_instr    out  32  instruction at FIFO head (to decode/signext)
//   dec_pc       out  N   byte address of dec_instr
// BEHAVIOUR
//   Reset (sync, clk edge with reset=1):
//   - fetch_pc=RESET_PC, FIFO count=0, state=IDLE.
//   - imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0.
//   - Reset in mid-request abandons the request; a late imem_ack is ignored.
//   FSM states:
//   - IDLE: imem_req=0. Go to FETCH when count<DEPTH.
//   - FETCH: imem_req=1, imem_addr=fetch_pc.
//   - DRAIN: imem_req=1, imem_addr=stale address. Data is discarded.
//   FETCH on ack (no redirect):
//   - push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps mod 2^N).
//   - Stay in FETCH if post-push/pop count<DEPTH, else go to IDLE.
//   - With zero-latency memory (ack in same cycle), one instruction per cycle.
//   Single outstanding request:
//   - A slot is always free when ack arrives, so a push never overflows.
//   Pop:
//   - dec_valid = (count!=0). Pop when dec_valid & dec_ready.
//   - Push and pop in the same cycle leave count unchanged.
//   - Entries leave in program order. Head outputs hold while dec_ready=0.
//   Redirect (highest priority after reset):
//   - Flush FIFO (count=0, dec_valid=0 next cycle); fetch_pc=redirect_pc&~3.
//   - Any same-cycle pop or push is cancelled.
//   - FETCH, ack same cycle: data dropped; next state FETCH at new PC.
//   - FETCH, no ack: go to DRAIN and keep req/addr stable (protocol rule).
//   - DRAIN on ack: drop data, go to FETCH at fetch_pc.
//   - Redirect during DRAIN: update fetch_pc (latest wins), stay in DRAIN.
//   - IDLE: go to FETCH at new PC.
//   Latency:
//   - First imem_req asserts 1 cycle after reset deasserts.
//   - An entry is visible on dec_* the cycle after its ack edge.
//   - Redirect to first new dec_valid is >= 2 cycles (ack-dependent).
//   Invariants:
//   - imem_addr[1:0]=00 always.
//   - imem_req never drops before ack except on reset.
//   - dec_pc of consecutive pops differs by 4 unless a redirect intervenes.
// TESTING
//   1. Reset; RESET_PC=0; ack in same cycle; dec_ready=1 -> dec_pc 0,4,8,12
//      on consecutive cycles; dec_instr matches memory.
//   2. dec_ready=0 for 6 cycles (DEPTH=2) -> exactly 2 pushes, then
//      imem_req=0. Release -> pops PC 0,4 then fetch resumes at 8.
//   3. Memory ack latency 3; redirect to 0x40 in 2nd wait cycle -> req/addr
//      held until ack, that word dropped, next req addr=0x40, dec_pc=0x40.
//   4. Redirect to 0x83 with FIFO full and dec_ready=1 same cycle -> no pop
//      counted, FIFO empty, next fetch addr=0x80.
//   5. Two redirects (0x100, then 0x200) during DRAIN -> only 0x200 fetched;
//      no entry with dec_pc 0x100 appears.
//   6. Assert reset while imem_req=1 with pending ack -> next cycle req=0,
//      dec_valid=0; late ack ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, issues single-outstanding word
// fetches to instruction memory, buffers returned words with their PCs in a
// small FIFO and presents the head entry to decode. A redirect flushes the
// stage; a request already on the bus is drained before the new PC is fetched.
//
// Handshakes:
//   imem side - imem_req/imem_addr are held stable until the cycle imem_ack=1;
//               that cycle completes the request and imem_rdata is sampled.
//   dec side  - an entry transfers on a clock edge where dec_valid=1 and
//               dec_ready=1; dec_instr/dec_pc hold while dec_ready=0.
module fetch_unit #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [N-1:0]  redirect_pc,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [31:0]   dec_instr,
    output logic [N-1:0]  dec_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // IDLE: FIFO full, no request. FETCH: request at fetch_pc.
    // DRAIN: request at a stale address whose data will be dropped.
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [N-1:0]      fetch_pc, fetch_pc_nxt;
    logic [N-1:0]      drain_addr, drain_addr_nxt;
    logic [N-1:0]      redir_pc;

    logic [31:0]       instr_mem [DEPTH];
    logic [N-1:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count, post_count;
    logic              push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Redirect target is always word aligned.
    assign redir_pc   = redirect_pc & ~N'(3);

    // A redirect cancels any push or pop in the same cycle.
    assign push       = (state == FETCH) && imem_ack && !redirect;
    assign dec_valid  = (count != '0);
    assign pop        = dec_valid && dec_ready && !redirect;
    assign post_count = count + CNT_W'(push) - CNT_W'(pop);

    assign dec_instr  = dec_valid ? instr_mem[head] : '0;
    assign dec_pc     = dec_valid ? pc_mem[head]    : '0;

    // State, PC and drain-address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            drain_addr <= drain_addr_nxt;
        end
    end

    // Next-state, PC update and memory-request outputs.
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        drain_addr_nxt = drain_addr;
        imem_req       = 1'b0;
        imem_addr      = fetch_pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt = redir_pc;
                    state_nxt    = FETCH;
                end else if (count < DEPTH_C) begin
                    state_nxt    = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    fetch_pc_nxt = redir_pc;
                    if (imem_ack) begin
                        state_nxt = FETCH;
                    end else begin
                        // Request must stay on the bus at its original address.
                        drain_addr_nxt = fetch_pc;
                        state_nxt      = DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_pc_nxt = fetch_pc + N'(4);
                    state_nxt    = (post_count < DEPTH_C) ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (redirect) begin
                    fetch_pc_nxt = redir_pc;
                end
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; redirect empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            count <= post_count;
        end
    end

    // FIFO storage: instruction word together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail] <= imem_rdata;
            pc_mem[tail]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (N=64, RESET_PC=0, DEPTH=2).
// Instruction memory returns {16'hC0DE, addr[15:0]} for every address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;

  logic        ack_always;
  logic        ack_drv;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  // memory model: zero-latency mode acks every request in the same cycle
  assign imem_ack   = ack_always ? imem_req : ack_drv;
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_unit #(.N(64), .RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc)
  );

  // one clock edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    ack_always  = 1'b1;
    ack_drv     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b1;

    // ---- 1: reset values, then streaming at one instruction per cycle
    step();
    step();
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", {63'd0, dec_valid}, 64'd0);
    chk("rst_instr", {32'd0, dec_instr}, 64'h0);
    chk("rst_pc", dec_pc, 64'h0);
    reset = 1'b0;
    step();
    chk("t1_first_req", {63'd0, imem_req}, 64'd1);
    chk("t1_first_addr", imem_addr, 64'h0);
    step();
    chk("t1_v0", {63'd0, dec_valid}, 64'd1);
    chk("t1_pc0", dec_pc, 64'h0);
    chk("t1_in0", {32'd0, dec_instr}, 64'hC0DE_0000);
    step();
    chk("t1_pc4", dec_pc, 64'h4);
    chk("t1_in4", {32'd0, dec_instr}, 64'hC0DE_0004);
    step();
    chk("t1_pc8", dec_pc, 64'h8);
    step();
    chk("t1_pc12", dec_pc, 64'hC);
    chk("t1_in12", {32'd0, dec_instr}, 64'hC0DE_000C);

    // ---- 2: back-pressure fills DEPTH=2 entries, fetch stalls, then resumes
    dec_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    chk("t2_stall_req", {63'd0, imem_req}, 64'd0);
    chk("t2_stall_addr", imem_addr, 64'h8);
    chk("t2_head_pc", dec_pc, 64'h0);
    dec_ready = 1'b1;
    step();
    chk("t2_pop_pc4", dec_pc, 64'h4);
    chk("t2_still_idle", {63'd0, imem_req}, 64'd0);
    step();
    chk("t2_empty", {63'd0, dec_valid}, 64'd0);
    chk("t2_resume_req", {63'd0, imem_req}, 64'd1);
    chk("t2_resume_addr", imem_addr, 64'h8);
    step();
    chk("t2_pc8", dec_pc, 64'h8);

    // ---- 3: latency-3 memory, redirect in 2nd wait cycle -> drain
    ack_always = 1'b0;
    ack_drv    = 1'b0;
    do_reset();
    step();
    chk("t3_req", {63'd0, imem_req}, 64'd1);
    step();
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    step();
    redirect = 1'b0;
    chk("t3_drain_req", {63'd0, imem_req}, 64'd1);
    chk("t3_drain_addr", imem_addr, 64'h0);
    ack_drv = 1'b1;
    step();
    chk("t3_dropped", {63'd0, dec_valid}, 64'd0);
    chk("t3_new_req", {63'd0, imem_req}, 64'd1);
    chk("t3_new_addr", imem_addr, 64'h40);
    step();
    ack_drv = 1'b0;
    chk("t3_valid", {63'd0, dec_valid}, 64'd1);
    chk("t3_pc", dec_pc, 64'h40);
    chk("t3_instr", {32'd0, dec_instr}, 64'hC0DE_0040);
    step();
    chk("t3_popped", {63'd0, dec_valid}, 64'd0);
    chk("t3_next_addr", imem_addr, 64'h44);

    // ---- 4: redirect to unaligned 0x83 with FIFO full and dec_ready=1
    ack_always = 1'b1;
    dec_ready  = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    chk("t4_full_req", {63'd0, imem_req}, 64'd0);
    redirect    = 1'b1;
    redirect_pc = 64'h83;
    dec_ready   = 1'b1;
    step();
    redirect = 1'b0;
    chk("t4_flushed", {63'd0, dec_valid}, 64'd0);
    chk("t4_req", {63'd0, imem_req}, 64'd1);
    chk("t4_addr", imem_addr, 64'h80);
    step();
    chk("t4_pc80", dec_pc, 64'h80);
    // redirect in FETCH with ack in the same cycle: word dropped, pop cancelled
    redirect    = 1'b1;
    redirect_pc = 64'h10;
    step();
    redirect = 1'b0;
    chk("t4b_flushed", {63'd0, dec_valid}, 64'd0);
    chk("t4b_addr", imem_addr, 64'h10);
    step();
    chk("t4b_pc", dec_pc, 64'h10);

    // ---- 5: two redirects while draining, latest target wins
    ack_always = 1'b0;
    ack_drv    = 1'b0;
    do_reset();
    step();
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    step();
    redirect_pc = 64'h200;
    step();
    redirect = 1'b0;
    chk("t5_drain_req", {63'd0, imem_req}, 64'd1);
    chk("t5_drain_addr", imem_addr, 64'h0);
    ack_drv = 1'b1;
    step();
    chk("t5_dropped", {63'd0, dec_valid}, 64'd0);
    chk("t5_addr", imem_addr, 64'h200);
    step();
    ack_drv = 1'b0;
    chk("t5_valid", {63'd0, dec_valid}, 64'd1);
    chk("t5_pc", dec_pc, 64'h200);
    chk("t5_instr", {32'd0, dec_instr}, 64'hC0DE_0200);

    // ---- 6: reset in mid-request, late ack ignored, restart at RESET_PC
    do_reset();
    step();
    chk("t6_req", {63'd0, imem_req}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_req", {63'd0, imem_req}, 64'd0);
    chk("t6_rst_valid", {63'd0, dec_valid}, 64'd0);
    ack_drv = 1'b1;
    step();
    chk("t6_late_ack", {63'd0, dec_valid}, 64'd0);
    chk("t6_restart_req", {63'd0, imem_req}, 64'd1);
    chk("t6_restart_addr", imem_addr, 64'h0);
    step();
    ack_drv = 1'b0;
    chk("t6_valid", {63'd0, dec_valid}, 64'd1);
    chk("t6_pc", dec_pc, 64'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
